// File: rtl/point_cloud_streamer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : point_pkg
//  Purpose  : Shared definitions for the point-cloud streamer: coordinate
//             widths, packed point layout, empty-slot sentinel, FSM states
//             and the sine generator used to build the trig ROM.
//  Revision : 1.0  initial release
// ============================================================================
package point_pkg;

  // Coordinate widths and packed {x, y, z} layout in memory words
  localparam int X_W   = 9;
  localparam int Y_W   = 8;
  localparam int Z_W   = 9;
  localparam int PT_W  = X_W + Y_W + Z_W;
  localparam int X_LSB = 17;
  localparam int Y_LSB = 9;
  localparam int Z_LSB = 0;

  // A y value of all ones marks an empty memory slot
  localparam logic [Y_W-1:0] Y_SENTINEL = 8'hFF;

  // Horizontal screen centre used by the downstream projection stage
  localparam int SCREEN_CENTER = 160;

  // Q1.15 full scale, also the cosine value at angle 0
  localparam logic signed [15:0] TRIG_ONE = 16'sd32767;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_LOAD_ANGLE = 2'd1,
    ST_STREAM     = 2'd2,
    ST_DRAIN      = 2'd3
  } state_t;

  // pi in unsigned Q4.60
  localparam logic [127:0] PI_Q60 = 128'h3243F6A8885A308D;

  // round(32767*sin(2*pi*k/256)). The first quadrant is evaluated with a
  // Taylor series in Q60 fixed point, which is far more precise than the
  // final 16-bit rounding needs; the other quadrants follow by symmetry.
  // Only ever called with constant arguments to build the ROM.
  function automatic logic signed [15:0] trig_sin(input logic [7:0] k);
    logic [6:0]   r;
    logic [127:0] x;
    logic [127:0] x2;
    logic [127:0] term;
    logic [127:0] sum;
    logic [127:0] mag;
    r    = k[6] ? (7'd64 - {1'b0, k[5:0]}) : {1'b0, k[5:0]};
    x    = (PI_Q60 * {121'd0, r}) >> 7;
    x2   = (x * x) >> 60;
    term = x;
    sum  = x;
    // Terms shrink monotonically for x <= pi/2, so partial sums stay positive
    for (int n = 1; n <= 12; n++) begin
      term = ((term * x2) >> 60) / 128'((2 * n) * (2 * n + 1));
      if (n[0]) sum = sum - term;
      else      sum = sum + term;
    end
    mag = (sum * 128'd32767 + (128'd1 << 59)) >> 60;
    trig_sin = k[7] ? -$signed(mag[15:0]) : $signed(mag[15:0]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/point_cloud_streamer_if.sv
`default_nettype none
// ============================================================================
//  Module   : point_cloud_streamer_if
//  Purpose  : Point-memory read bus plus the x/y/z point stream toward the
//             projection stage.
//  Revision : 1.0  initial release
// ============================================================================
interface point_cloud_streamer_if #(
  parameter int ADDR_W = 10
) ();
  import point_pkg::*;

  logic [ADDR_W-1:0] mem_addr_out;
  logic [PT_W-1:0]   mem_data_in;
  logic [X_W-1:0]    x_out;
  logic [Y_W-1:0]    y_out;
  logic [Z_W-1:0]    z_out;
  logic              valid_out;

  // Streamer side: drives the address and the point stream
  modport master (
    output mem_addr_out,
    input  mem_data_in,
    output x_out,
    output y_out,
    output z_out,
    output valid_out
  );

  // Memory / consumer side
  modport slave (
    input  mem_addr_out,
    output mem_data_in,
    input  x_out,
    input  y_out,
    input  z_out,
    input  valid_out
  );
endinterface
`default_nettype wire

// File: rtl/point_cloud_streamer_trig_lut.sv
`default_nettype none
// ============================================================================
//  Module   : trig_lut
//  Purpose  : 256-entry Q1.15 cosine/sine ROM indexed by an 8-bit angle.
//  Revision : 1.0  initial release
// ============================================================================
module trig_lut
  import point_pkg::*;
(
  input  logic        [7:0]  angle_in,
  output logic signed [15:0] cos_out,
  output logic signed [15:0] sin_out
);

  logic signed [15:0] cos_rom [256];
  logic signed [15:0] sin_rom [256];

  // Each entry is an elaboration-time constant; cos(k) is sin(k + quarter turn)
  for (genvar k = 0; k < 256; k++) begin : g_rom
    localparam logic signed [15:0] COS_K = trig_sin(8'(k + 64));
    localparam logic signed [15:0] SIN_K = trig_sin(8'(k));
    assign cos_rom[k] = COS_K;
    assign sin_rom[k] = SIN_K;
  end

  assign cos_out = cos_rom[angle_in];
  assign sin_out = sin_rom[angle_in];

endmodule
`default_nettype wire

// File: rtl/point_cloud_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : point_cloud_streamer
//  Purpose  : Streams NUM_POINTS packed points from a 2-cycle-latency memory
//             per frame, drops empty slots, and presents the frame's
//             rotation angle as Q1.15 cosine/sine.
//  Revision : 1.0  initial release
// ============================================================================
module point_cloud_streamer
  import point_pkg::*;
#(
  parameter int NUM_POINTS = 1024,
  parameter int ADDR_W     = 10,
  parameter int ANGLE_STEP = 1
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               frame_start_in,
  input  logic               rotate_en_in,
  point_cloud_streamer_if.master bus_if,
  output logic signed [15:0] cos_out,
  output logic signed [15:0] sin_out,
  output logic               busy_out,
  output logic               frame_done_out,
  output logic               overrun_out
);

  // Truncation to 8 bits is exactly "mod 256" for the angle step
  localparam logic [7:0]        ANGLE_INC = 8'(ANGLE_STEP);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_POINTS - 1);

  state_t             state_q;
  logic [7:0]         angle_q;
  logic [7:0]         angle_d;
  logic [ADDR_W-1:0]  addr_q;
  logic [2:0]         issue_q;
  logic               issue_d;
  logic signed [15:0] cos_q;
  logic signed [15:0] sin_q;
  logic signed [15:0] lut_cos;
  logic signed [15:0] lut_sin;
  logic               busy_q;
  logic               done_q;
  logic               overrun_q;

  logic [X_W-1:0]     x_q;
  logic [Y_W-1:0]     y_q;
  logic [Z_W-1:0]     z_q;
  logic               valid_q;

  logic [X_W-1:0]     mem_x;
  logic [Y_W-1:0]     mem_y;
  logic [Z_W-1:0]     mem_z;
  logic               point_ok;

  trig_lut u_trig_lut (
    .angle_in (angle_q),
    .cos_out  (lut_cos),
    .sin_out  (lut_sin)
  );

  assign angle_d = angle_q + ANGLE_INC;

  // An address is issued on the LOAD_ANGLE exit edge (address 0) and on
  // every STREAM edge that still has addresses left
  always_comb begin
    issue_d = 1'b0;
    if (state_q == ST_LOAD_ANGLE) begin
      issue_d = 1'b1;
    end else if (state_q == ST_STREAM && addr_q != LAST_ADDR) begin
      issue_d = 1'b1;
    end
  end

  // Frame sequencing, angle, address counter and issue tracking
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= ST_IDLE;
      angle_q   <= 8'd0;
      addr_q    <= '0;
      issue_q   <= 3'b000;
      cos_q     <= TRIG_ONE;
      sin_q     <= 16'sd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      issue_q <= {issue_q[1:0], issue_d};

      if (frame_start_in && state_q != ST_IDLE) begin
        overrun_q <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (frame_start_in) begin
            state_q <= ST_LOAD_ANGLE;
            busy_q  <= 1'b1;
            if (rotate_en_in) begin
              angle_q <= angle_d;
            end
          end
        end
        ST_LOAD_ANGLE: begin
          cos_q   <= lut_cos;
          sin_q   <= lut_sin;
          addr_q  <= '0;
          state_q <= ST_STREAM;
        end
        ST_STREAM: begin
          if (addr_q == LAST_ADDR) begin
            state_q <= ST_DRAIN;
          end else begin
            addr_q <= addr_q + ADDR_W'(1);
          end
        end
        ST_DRAIN: begin
          if (issue_q == 3'b000) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_x    = bus_if.mem_data_in[X_LSB +: X_W];
  assign mem_y    = bus_if.mem_data_in[Y_LSB +: Y_W];
  assign mem_z    = bus_if.mem_data_in[Z_LSB +: Z_W];
  assign point_ok = issue_q[2] && (mem_y != Y_SENTINEL);

  // Output stage: capture tracked reads, holding x/y/z across empty slots
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= point_ok;
      if (point_ok) begin
        x_q <= mem_x;
        y_q <= mem_y;
        z_q <= mem_z;
      end
    end
  end

  assign bus_if.mem_addr_out = addr_q;
  assign bus_if.x_out        = x_q;
  assign bus_if.y_out        = y_q;
  assign bus_if.z_out        = z_q;
  assign bus_if.valid_out    = valid_q;

  assign cos_out        = cos_q;
  assign sin_out        = sin_q;
  assign busy_out       = busy_q;
  assign frame_done_out = done_q;
  assign overrun_out    = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_point_cloud_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_point_cloud_streamer
//  Purpose  : Self-checking bench for point_cloud_streamer. Two instances
//             (angle step 1 and 64) share stimulus and point memory contents.
//  Revision : 1.0  initial release
// ============================================================================
module tb_point_cloud_streamer;

  localparam int NP = 4;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_start = 1'b0;
  logic rotate_en = 1'b0;

  logic signed [15:0] cos_a, sin_a, cos_b, sin_b;
  logic busy_a, done_a, ovr_a, busy_b, done_b, ovr_b;

  logic [25:0] mem [NP];
  logic [25:0] rd1_a, rd2_a, rd1_b, rd2_b;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ang_a = 0;
  int ang_b = 0;
  int done_cnt_a = 0;

  logic [25:0] exp_q[$];
  logic [25:0] got_a[$];
  logic [25:0] got_b[$];
  logic [31:0] trig_seen_b[$];

  point_cloud_streamer_if #(.ADDR_W(AW)) bus_a ();
  point_cloud_streamer_if #(.ADDR_W(AW)) bus_b ();

  point_cloud_streamer #(.NUM_POINTS(NP), .ADDR_W(AW), .ANGLE_STEP(1)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .frame_start_in(frame_start),
    .rotate_en_in(rotate_en), .bus_if(bus_a), .cos_out(cos_a), .sin_out(sin_a),
    .busy_out(busy_a), .frame_done_out(done_a), .overrun_out(ovr_a));

  point_cloud_streamer #(.NUM_POINTS(NP), .ADDR_W(AW), .ANGLE_STEP(64)) dut64 (
    .clk_in(clk), .rst_n_in(rst_n), .frame_start_in(frame_start),
    .rotate_en_in(rotate_en), .bus_if(bus_b), .cos_out(cos_b), .sin_out(sin_b),
    .busy_out(busy_b), .frame_done_out(done_b), .overrun_out(ovr_b));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory with two-cycle read latency, one pipe per instance
  always @(posedge clk) begin
    rd1_a <= mem[bus_a.mem_addr_out[1:0]];
    rd2_a <= rd1_a;
    rd1_b <= mem[bus_b.mem_addr_out[1:0]];
    rd2_b <= rd1_b;
  end
  assign bus_a.mem_data_in = rd2_a;
  assign bus_b.mem_data_in = rd2_b;

  always @(negedge clk) begin
    if (bus_a.valid_out) got_a.push_back({bus_a.x_out, bus_a.y_out, bus_a.z_out});
    if (bus_b.valid_out) begin
      got_b.push_back({bus_b.x_out, bus_b.y_out, bus_b.z_out});
      trig_seen_b.push_back({cos_b, sin_b});
    end
    if (done_a) done_cnt_a++;
  end

  // Reference trig values straight from the real-valued definition
  function automatic int ref_trig(input int a, input bit want_sin);
    real th, v;
    th = 2.0 * 3.14159265358979323846 * a / 256.0;
    v  = 32767.0 * (want_sin ? $sin(th) : $cos(th));
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; frame_start = 1'b0; rotate_en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ang_a = 0; ang_b = 0;
  endtask

  // Loads fresh random points, runs one frame, reports latency to frame_done
  task automatic run_frame(input bit rot, input int sent, input bit extra,
                           output int lat, output bit tmo, output bit busy_mid);
    logic [25:0] p;
    int start;
    exp_q.delete(); got_a.delete(); got_b.delete(); trig_seen_b.delete();
    for (int i = 0; i < NP; i++) begin
      p[25:17] = 9'($urandom);
      p[16:9]  = 8'($urandom_range(0, 254));
      p[8:0]   = 9'($urandom);
      if (i == sent) p[16:9] = 8'hFF;
      mem[i] = p;
      if (i != sent) exp_q.push_back(p);
    end
    if (rot) begin ang_a = (ang_a + 1) % 256; ang_b = (ang_b + 64) % 256; end
    @(negedge clk);
    frame_start = 1'b1; rotate_en = rot; start = cyc;
    tmo = 1'b1; lat = 0; busy_mid = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      frame_start = extra && (cyc - start == 3);
      rotate_en   = frame_start;
      if (cyc - start == 2) busy_mid = busy_a;
      if (done_a) begin lat = cyc - start; tmo = 1'b0; break; end
    end
    frame_start = 1'b0; rotate_en = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus_a.valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus_a.valid_out); end
    total++; if (done_a !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done_a); end
    total++; if (ovr_a !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b want 0", ovr_a); end
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy_a); end
    total++; if ({bus_a.x_out, bus_a.y_out, bus_a.z_out} !== 26'd0) begin bad++; $display("FAIL reset_xyz: got %h want 0", {bus_a.x_out, bus_a.y_out, bus_a.z_out}); end
    total++; if (bus_a.mem_addr_out !== 10'd0) begin bad++; $display("FAIL reset_addr: got %0d want 0", bus_a.mem_addr_out); end
    total++; if (cos_a !== 16'sd32767 || sin_a !== 16'sd0) begin bad++; $display("FAIL reset_trig: got %0d/%0d want 32767/0", cos_a, sin_a); end
  endtask

  task automatic test_identity_frame();
    int lat; bit tmo; bit bm;
    run_frame(1'b0, -1, 1'b0, lat, tmo, bm);
    total++; if (tmo !== 1'b0) begin bad++; $display("FAIL ident_timeout: frame_done never seen"); end
    total++; if (lat != 9) begin bad++; $display("FAIL ident_latency: got %0d want 9", lat); end
    total++; if (bm !== 1'b1) begin bad++; $display("FAIL ident_busy_mid: got %b want 1", bm); end
    total++; if (got_a.size() != 4) begin bad++; $display("FAIL ident_beats: got %0d want 4", got_a.size()); end
    for (int i = 0; i < 4 && i < got_a.size(); i++) begin
      total++; if (got_a[i] !== exp_q[i]) begin bad++; $display("FAIL ident_point%0d: got %h want %h", i, got_a[i], exp_q[i]); end
    end
    total++; if (cos_a !== 16'sd32767 || sin_a !== 16'sd0) begin bad++; $display("FAIL ident_trig: got %0d/%0d want 32767/0", cos_a, sin_a); end
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL ident_busy_end: got %b want 0", busy_a); end
    total++; if (bus_a.mem_addr_out !== 10'd3) begin bad++; $display("FAIL ident_addr_hold: got %0d want 3", bus_a.mem_addr_out); end
  endtask

  task automatic test_sentinel();
    int lat; bit tmo; bit bm;
    run_frame(1'b0, 2, 1'b0, lat, tmo, bm);
    total++; if (got_a.size() != 3) begin bad++; $display("FAIL sent_beats: got %0d want 3", got_a.size()); end
    for (int i = 0; i < 3 && i < got_a.size(); i++) begin
      total++; if (got_a[i] !== exp_q[i]) begin bad++; $display("FAIL sent_point%0d: got %h want %h", i, got_a[i], exp_q[i]); end
    end
    total++; if (lat != 9) begin bad++; $display("FAIL sent_latency: got %0d want 9", lat); end
  endtask

  task automatic test_rotate_quarter();
    int lat; bit tmo; bit bm; int unstable;
    do_reset();
    run_frame(1'b1, -1, 1'b0, lat, tmo, bm);
    total++; if (cos_b !== 16'sd0 || sin_b !== 16'sd32767) begin bad++; $display("FAIL quarter_trig: got %0d/%0d want 0/32767", cos_b, sin_b); end
    unstable = 0;
    foreach (trig_seen_b[i]) if (trig_seen_b[i] !== {16'sd0, 16'sd32767}) unstable++;
    total++; if (unstable != 0 || trig_seen_b.size() != 4) begin bad++; $display("FAIL quarter_stable: got %0d bad of %0d samples want 0 of 4", unstable, trig_seen_b.size()); end
    total++; if (cos_a !== 16'(ref_trig(ang_a, 0)) || sin_a !== 16'(ref_trig(ang_a, 1))) begin bad++; $display("FAIL step1_trig: got %0d/%0d want %0d/%0d", cos_a, sin_a, ref_trig(ang_a, 0), ref_trig(ang_a, 1)); end
  endtask

  task automatic test_overrun();
    int lat; bit tmo; bit bm;
    do_reset();
    run_frame(1'b0, -1, 1'b1, lat, tmo, bm);
    total++; if (ovr_a !== 1'b1) begin bad++; $display("FAIL ovr_flag: got %b want 1", ovr_a); end
    total++; if (lat != 9) begin bad++; $display("FAIL ovr_latency: got %0d want 9", lat); end
    total++; if (got_a.size() != 4) begin bad++; $display("FAIL ovr_beats: got %0d want 4", got_a.size()); end
    run_frame(1'b1, -1, 1'b0, lat, tmo, bm);
    total++; if (cos_a !== 16'(ref_trig(ang_a, 0)) || sin_a !== 16'(ref_trig(ang_a, 1))) begin bad++; $display("FAIL ovr_angle: got %0d/%0d want %0d/%0d", cos_a, sin_a, ref_trig(ang_a, 0), ref_trig(ang_a, 1)); end
    total++; if (ovr_a !== 1'b1) begin bad++; $display("FAIL ovr_sticky: got %b want 1", ovr_a); end
  endtask

  task automatic test_random_frames();
    int lat; bit tmo; bit bm; int sent; bit rot; int errs;
    do_reset();
    for (int f = 0; f < 24; f++) begin
      rot  = 1'($urandom);
      sent = $urandom_range(0, 4) - 1;
      run_frame(rot, sent, 1'b0, lat, tmo, bm);
      errs = 0;
      if (got_a.size() != exp_q.size() || got_b.size() != exp_q.size()) errs++;
      else foreach (exp_q[i]) if (got_a[i] !== exp_q[i] || got_b[i] !== exp_q[i]) errs++;
      total++; if (errs != 0) begin bad++; $display("FAIL rand_stream f%0d: got %0d/%0d beats want %0d (errs %0d)", f, got_a.size(), got_b.size(), exp_q.size(), errs); end
      total++; if (lat != 9) begin bad++; $display("FAIL rand_latency f%0d: got %0d want 9", f, lat); end
      total++; if (cos_b !== 16'(ref_trig(ang_b, 0)) || sin_b !== 16'(ref_trig(ang_b, 1))) begin bad++; $display("FAIL rand_trig64 f%0d: got %0d/%0d want %0d/%0d", f, cos_b, sin_b, ref_trig(ang_b, 0), ref_trig(ang_b, 1)); end
      total++; if (cos_a !== 16'(ref_trig(ang_a, 0)) || sin_a !== 16'(ref_trig(ang_a, 1))) begin bad++; $display("FAIL rand_trig1 f%0d: got %0d/%0d want %0d/%0d", f, cos_a, sin_a, ref_trig(ang_a, 0), ref_trig(ang_a, 1)); end
    end
  endtask

  task automatic test_angle_wrap();
    int lat; bit tmo; bit bm;
    do_reset();
    for (int f = 0; f < 256; f++) begin
      run_frame(1'b1, -1, 1'b0, lat, tmo, bm);
      total++; if (tmo || cos_a !== 16'(ref_trig(ang_a, 0)) || sin_a !== 16'(ref_trig(ang_a, 1))) begin bad++; $display("FAIL wrap_trig f%0d: got %0d/%0d want %0d/%0d tmo %b", f, cos_a, sin_a, ref_trig(ang_a, 0), ref_trig(ang_a, 1), tmo); end
    end
    total++; if (cos_a !== 16'sd32767 || sin_a !== 16'sd0) begin bad++; $display("FAIL wrap_final: got %0d/%0d want 32767/0", cos_a, sin_a); end
  endtask

  task automatic test_reset_mid_stream();
    int lat; bit tmo; bit bm; bit seen; int dc;
    do_reset();
    for (int i = 0; i < NP; i++) mem[i] = {9'd5, 8'(i + 1), 9'd7};
    @(negedge clk); frame_start = 1'b1; rotate_en = 1'b1;
    @(negedge clk); frame_start = 1'b0; rotate_en = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus_a.valid_out) begin seen = 1'b1; break; end
    end
    total++; if (!seen) begin bad++; $display("FAIL midrst_no_valid: valid_out never rose"); end
    dc = done_cnt_a;
    #1 rst_n = 1'b0;
    #1;
    total++; if (bus_a.valid_out !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b want 0", bus_a.valid_out); end
    total++; if (busy_a !== 1'b0 || cos_a !== 16'sd32767 || sin_a !== 16'sd0) begin bad++; $display("FAIL midrst_state: busy %b trig %0d/%0d want 0 32767/0", busy_a, cos_a, sin_a); end
    total++; if ({bus_a.x_out, bus_a.y_out, bus_a.z_out} !== 26'd0 || bus_a.mem_addr_out !== 10'd0) begin bad++; $display("FAIL midrst_outputs: xyz %h addr %0d want 0 0", {bus_a.x_out, bus_a.y_out, bus_a.z_out}, bus_a.mem_addr_out); end
    @(negedge clk); rst_n = 1'b1;
    ang_a = 0; ang_b = 0;
    repeat (20) @(negedge clk);
    total++; if (done_cnt_a != dc) begin bad++; $display("FAIL midrst_done: got %0d pulses want 0", done_cnt_a - dc); end
    run_frame(1'b0, -1, 1'b0, lat, tmo, bm);
    total++; if (lat != 9 || cos_a !== 16'sd32767) begin bad++; $display("FAIL midrst_recover: lat %0d cos %0d want 9 32767", lat, cos_a); end
  endtask

  initial begin
    test_reset();
    test_identity_frame();
    test_sentinel();
    test_rotate_quarter();
    test_overrun();
    test_random_frames();
    test_angle_wrap();
    test_reset_mid_stream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/point_cloud_streamer.md
POINT_CLOUD_STREAMER -- requirements
Module: point_cloud_streamer

Interface
REQ-001 SHALL have parameter NUM_POINTS, default 1024: number of point-memory entries streamed per frame.
REQ-002 SHALL have parameter ADDR_W, default 10: point-memory address width; NUM_POINTS <= 2**ADDR_W.
REQ-003 SHALL have parameter ANGLE_STEP, default 1: angle increment, in LUT steps, applied per frame.
REQ-004 SHALL have port clk_in, input, 1: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n_in, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port frame_start_in, input, 1: one-cycle pulse that starts a frame.
REQ-007 SHALL have port rotate_en_in, input, 1: when 1, the angle advances at each accepted frame start.
REQ-008 SHALL have port mem_addr_out, output, ADDR_W: point-memory read address.
REQ-009 SHALL have port mem_data_in, input, 26: packed {x[25:17], y[16:9], z[8:0]} from memory, 2-cycle read latency.
REQ-010 SHALL have port x_out, output, 9: point x.
REQ-011 SHALL have port y_out, output, 8: point y.
REQ-012 SHALL have port z_out, output, 9: point z.
REQ-013 SHALL have port valid_out, output, 1: x/y/z qualifier, feeding the projection stage's valid_in.
REQ-014 SHALL have port cos_out, output, signed 16: Q1.15 cosine of the current angle.
REQ-015 SHALL have port sin_out, output, signed 16: Q1.15 sine of the current angle.
REQ-016 SHALL have port busy_out, output, 1: high while not IDLE.
REQ-017 SHALL have port frame_done_out, output, 1: one-cycle pulse when the frame completes.
REQ-018 SHALL have port overrun_out, output, 1: sticky; set when a frame start is ignored.

Function
REQ-019 SHALL implement FSM states IDLE, LOAD_ANGLE, STREAM, DRAIN.
REQ-020 IDLE: frame_start_in=1 -> LOAD_ANGLE; if rotate_en_in=1, angle <= (angle + ANGLE_STEP) mod 256.
REQ-021 LOAD_ANGLE (1 cycle): register cos_out/sin_out from trig_lut(angle), reset address counter to 0, then -> STREAM.
REQ-022 cos_out/sin_out SHALL change only on the LOAD_ANGLE exit edge and stay constant until the next frame's LOAD_ANGLE.
REQ-023 STREAM: issue one address per cycle, 0..NUM_POINTS-1; after issuing NUM_POINTS-1 -> DRAIN.
REQ-024 Read pipeline: a 3-deep issue-valid shift register tracks addresses; data for address issued at cycle t is registered to x/y/z_out at t+3.
REQ-025 valid_out SHALL be 1 at t+3 only if the tracked issue was valid and y != 8'hFF (empty-slot sentinel); sentinel slots produce valid_out=0 and x/y/z_out hold.
REQ-026 DRAIN: wait until the shift register is empty, pulse frame_done_out for 1 cycle, then -> IDLE.
REQ-027 frame_start_in outside IDLE SHALL be ignored (no angle change) and SHALL set overrun_out until reset.
REQ-028 Angle SHALL wrap from 255 to 0 without a glitch; ANGLE_STEP is interpreted mod 256.
REQ-029 trig_lut entry k SHALL be round(32767*cos(2*pi*k/256)) and round(32767*sin(2*pi*k/256)); k=0 gives 32767/0, k=64 gives 0/32767.
REQ-030 mem_addr_out SHALL hold its last value when not in STREAM.
REQ-031 Minimum frame length SHALL be NUM_POINTS+5 cycles from frame_start_in to frame_done_out.

Reset
REQ-032 On rst_n_in=0, asynchronously: state=IDLE, angle=0, address=0, pipeline empty, valid_out=0, frame_done_out=0, overrun_out=0, x/y/z_out=0, mem_addr_out=0, cos_out=32767, sin_out=0.
REQ-033 Reset mid-STREAM SHALL abort the frame with no frame_done_out pulse, and valid_out SHALL be 0 from the reset edge.

Structure
REQ-034 Shared package point_pkg SHALL hold the coordinate widths (9/8/9), the packed-point field positions, the sentinel 8'hFF, SCREEN_CENTER=160, and the FSM state enum.
REQ-035 Sine/cosine table SHALL be sub-module trig_lut: 8-bit angle in, two signed 16-bit outputs, combinational ROM.

Verification
REQ-036 Reset, then frame_start with rotate_en=0 and NUM_POINTS=4 holding distinct points -> cos=32767, sin=0, 4 valid_out beats with data in address order, frame_done at frame start +9 cycles.
REQ-037 rotate_en=1, ANGLE_STEP=64, frame started once -> cos_out=0 and sin_out=32767, stable for the whole frame.
REQ-038 Address 2 holds y=8'hFF -> only 3 valid beats; the sentinel point is never emitted.
REQ-039 frame_start pulsed during STREAM -> ignored, overrun_out=1, angle unchanged, and the frame completes normally.
REQ-040 256 frames at ANGLE_STEP=1 -> angle wraps to 0, cos_out=32767 again.
REQ-041 rst_n_in low mid-STREAM -> valid_out=0 immediately, no frame_done, state IDLE, outputs at reset values.
